// File: rtl/core_pkg.sv
// Shared core types for the memory stage: datapath width default, funct3 size codes, LSU states.
package core_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension; purely combinational, no backpressure.
module lsu_load_align import core_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0]             i_rdata,
    input  logic [$clog2(XLEN/8)-1:0]   i_off,
    input  logic [2:0]                  i_funct3,
    output logic [XLEN-1:0]             o_result
);

    logic [XLEN-1:0] w_lane;

    assign w_lane = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_result = '0;
        case (i_funct3)
            F3_B:    o_result = XLEN'($signed(w_lane[7:0]));
            F3_H:    o_result = XLEN'($signed(w_lane[15:0]));
            F3_W:    o_result = XLEN'($signed(w_lane[31:0]));
            F3_D:    o_result = w_lane;
            F3_BU:   o_result = XLEN'(w_lane[7:0]);
            F3_HU:   o_result = XLEN'(w_lane[15:0]);
            F3_WU:   o_result = XLEN'(w_lane[31:0]);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: drives the data-memory request and registers results into WB (latency 1 after completion).
// Holds upstream via o_mem_stall while a memory op is outstanding or WB stalls; buffers load data in HOLD.
module mem_lsu_stage import core_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int RID_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mem_v,
    input  logic                i_mem_load,
    input  logic                i_mem_store,
    input  logic [2:0]          i_mem_funct3,
    input  logic [XLEN-1:0]     i_mem_npc,
    input  logic [XLEN-1:0]     i_mem_alu_result,
    input  logic [XLEN-1:0]     i_mem_sr2,
    input  logic [XLEN-1:0]     i_mem_csrfd,
    input  logic [RID_W-1:0]    i_mem_drid,
    input  logic                i_mem_ecall,
    input  logic                i_flush,
    input  logic                i_wb_stall,
    output logic                o_mem_stall,
    output logic                o_dm_req,
    output logic                o_dm_we,
    output logic [XLEN-1:0]     o_dm_addr,
    output logic [XLEN-1:0]     o_dm_wdata,
    output logic [XLEN/8-1:0]   o_dm_be,
    input  logic                i_dm_ready,
    input  logic                i_dm_rvalid,
    input  logic [XLEN-1:0]     i_dm_rdata,
    output logic                o_wb_v,
    output logic                o_wb_ecall,
    output logic                o_wb_fault,
    output logic [XLEN-1:0]     o_wb_npc,
    output logic [XLEN-1:0]     o_wb_alu_result,
    output logic [XLEN-1:0]     o_wb_mem_result,
    output logic [XLEN-1:0]     o_wb_csrfd,
    output logic [RID_W-1:0]    o_wb_drid
);

    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);

    lsu_state_t         r_state, w_state_nxt;
    logic               r_kill, w_kill_nxt;
    logic [XLEN-1:0]    r_hold_dat;

    logic               w_mem_op, w_misalign, w_unsup, w_fault, w_acc, w_pass;
    logic               w_done, w_busy, w_cap;
    logic [XLEN-1:0]    w_done_dat, w_ld_dat;
    logic [1:0]         w_size;
    logic [2:0]         w_alnmask;
    logic [OFFW-1:0]    w_off;
    logic [7:0]         w_mask8;

    logic               r_wb_v, r_wb_ecall, r_wb_fault;
    logic [XLEN-1:0]    r_wb_npc, r_wb_alu, r_wb_mem, r_wb_csrfd;
    logic [RID_W-1:0]   r_wb_drid;

    assign w_mem_op  = i_mem_v & (i_mem_load | i_mem_store);
    assign w_size    = i_mem_funct3[1:0];
    assign w_off     = i_mem_alu_result[OFFW-1:0];
    assign w_alnmask = {w_size == 2'd3, w_size[1], |w_size};
    assign w_misalign = |(i_mem_alu_result[2:0] & w_alnmask);
    assign w_unsup   = (i_mem_funct3 == 3'b111) |
                       ((XLEN == 32) & ((i_mem_funct3 == F3_D) | (i_mem_funct3 == F3_WU)));
    assign w_fault   = w_mem_op & (w_misalign | w_unsup);

    // Request only from IDLE/REQ; the upstream hold keeps address/data stable across REQ.
    assign w_acc  = i_rst_n & w_mem_op & ~w_fault & ~i_flush &
                    ((r_state == ST_IDLE) | (r_state == ST_REQ));
    assign w_pass = (r_state == ST_IDLE) & i_mem_v & ~i_flush & (~w_mem_op | w_fault);

    always_comb begin
        w_mask8 = 8'hFF;
        case (w_size)
            2'd0:    w_mask8 = 8'h01;
            2'd1:    w_mask8 = 8'h03;
            2'd2:    w_mask8 = 8'h0F;
            default: w_mask8 = 8'hFF;
        endcase
    end

    always_comb begin
        o_dm_wdata = i_mem_sr2;
        case (w_size)
            2'd0:    o_dm_wdata = {BW{i_mem_sr2[7:0]}};
            2'd1:    o_dm_wdata = {(BW/2){i_mem_sr2[15:0]}};
            2'd2:    o_dm_wdata = {(BW/4){i_mem_sr2[31:0]}};
            default: o_dm_wdata = i_mem_sr2;
        endcase
    end

    assign o_dm_req  = w_acc;
    assign o_dm_we   = w_mem_op & i_mem_store;
    assign o_dm_addr = i_mem_alu_result;
    assign o_dm_be   = w_mask8[BW-1:0] << w_off;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_rdata  (i_dm_rdata),
        .i_off    (w_off),
        .i_funct3 (i_mem_funct3),
        .o_result (w_ld_dat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_done      = 1'b0;
        w_done_dat  = '0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                w_state_nxt = ST_IDLE;
                if (w_acc) begin
                    if (!i_dm_ready) begin
                        w_state_nxt = ST_REQ;
                        w_busy      = 1'b1;
                    end else if (i_mem_load) begin
                        w_state_nxt = ST_WAIT;
                        w_busy      = 1'b1;
                    end else begin
                        // Store done at accept; park in HOLD so a stalled WB cannot cause a re-issue.
                        w_done      = 1'b1;
                        w_state_nxt = i_wb_stall ? ST_HOLD : ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (i_flush) w_kill_nxt = 1'b1;
                if (i_dm_rvalid) begin
                    w_busy     = 1'b0;
                    w_kill_nxt = 1'b0;
                    if (r_kill || i_flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_done      = 1'b1;
                        w_done_dat  = w_ld_dat;
                        w_state_nxt = i_wb_stall ? ST_HOLD : ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                w_done_dat = r_hold_dat;
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (!i_wb_stall) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_mem_stall = i_rst_n & (i_wb_stall | w_busy);
    assign w_cap       = w_done | w_pass;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_kill     <= 1'b0;
            r_hold_dat <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (w_done && i_wb_stall && (r_state != ST_HOLD)) r_hold_dat <= w_done_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_v     <= 1'b0;
            r_wb_ecall <= 1'b0;
            r_wb_fault <= 1'b0;
            r_wb_npc   <= '0;
            r_wb_alu   <= '0;
            r_wb_mem   <= '0;
            r_wb_csrfd <= '0;
            r_wb_drid  <= '0;
        end else if (!i_wb_stall) begin
            r_wb_v <= w_cap;
            if (w_cap) begin
                r_wb_ecall <= i_mem_ecall;
                r_wb_fault <= w_pass & w_fault;
                r_wb_npc   <= i_mem_npc;
                r_wb_alu   <= i_mem_alu_result;
                r_wb_mem   <= w_done ? w_done_dat : '0;
                r_wb_csrfd <= i_mem_csrfd;
                r_wb_drid  <= i_mem_drid;
            end
        end
    end

    assign o_wb_v          = r_wb_v;
    assign o_wb_ecall      = r_wb_ecall;
    assign o_wb_fault      = r_wb_fault;
    assign o_wb_npc        = r_wb_npc;
    assign o_wb_alu_result = r_wb_alu;
    assign o_wb_mem_result = r_wb_mem;
    assign o_wb_csrfd      = r_wb_csrfd;
    assign o_wb_drid       = r_wb_drid;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Scoreboard bench for mem_lsu_stage: expected WB records queued at issue, popped when WB fires.
module tb_mem_lsu_stage;
    import core_pkg::*;

    localparam int XLEN  = 64;
    localparam int RID_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_v, mem_load, mem_store, mem_ecall, flush, wb_stall;
    logic [2:0]        mem_funct3;
    logic [XLEN-1:0]   mem_npc, mem_alu, mem_sr2, mem_csrfd;
    logic [RID_W-1:0]  mem_drid;
    logic              o_mem_stall, o_dm_req, o_dm_we;
    logic [XLEN-1:0]   o_dm_addr, o_dm_wdata;
    logic [XLEN/8-1:0] o_dm_be;
    logic              dm_ready, dm_rvalid;
    logic [XLEN-1:0]   dm_rdata;
    logic              o_wb_v, o_wb_ecall, o_wb_fault;
    logic [XLEN-1:0]   o_wb_npc, o_wb_alu_result, o_wb_mem_result, o_wb_csrfd;
    logic [RID_W-1:0]  o_wb_drid;

    always #5 clk = ~clk;

    mem_lsu_stage #(.XLEN(XLEN), .RID_W(RID_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_v(mem_v), .i_mem_load(mem_load), .i_mem_store(mem_store),
        .i_mem_funct3(mem_funct3), .i_mem_npc(mem_npc), .i_mem_alu_result(mem_alu),
        .i_mem_sr2(mem_sr2), .i_mem_csrfd(mem_csrfd), .i_mem_drid(mem_drid),
        .i_mem_ecall(mem_ecall), .i_flush(flush), .i_wb_stall(wb_stall),
        .o_mem_stall(o_mem_stall), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
        .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .o_dm_be(o_dm_be),
        .i_dm_ready(dm_ready), .i_dm_rvalid(dm_rvalid), .i_dm_rdata(dm_rdata),
        .o_wb_v(o_wb_v), .o_wb_ecall(o_wb_ecall), .o_wb_fault(o_wb_fault),
        .o_wb_npc(o_wb_npc), .o_wb_alu_result(o_wb_alu_result),
        .o_wb_mem_result(o_wb_mem_result), .o_wb_csrfd(o_wb_csrfd), .o_wb_drid(o_wb_drid)
    );

    typedef struct packed {
        logic [63:0] npc;
        logic [63:0] alu;
        logic [63:0] mem;
        logic        fault;
    } wb_exp_t;

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [63:0] exp;
        logic        flt;
    } ld_vec_t;

    wb_exp_t   sb_q[$];
    wb_exp_t   mon_e;
    ld_vec_t   vec[11];
    int        n_checks = 0;
    int        n_errors = 0;
    int        nstall;
    logic      cap = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_op();
        mem_v = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
        dm_ready = 1'b0; dm_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sr2, input logic [63:0] npc);
        mem_v = 1'b1; mem_load = ld; mem_store = st; mem_funct3 = f3;
        mem_alu = addr; mem_sr2 = sr2; mem_npc = npc;
        mem_csrfd = npc ^ 64'hFF; mem_drid = npc[6:2]; mem_ecall = 1'b0;
    endtask

    task automatic push(input logic [63:0] npc, input logic [63:0] alu,
                        input logic [63:0] mem, input logic flt);
        wb_exp_t e;
        e.npc = npc; e.alu = alu; e.mem = mem; e.fault = flt;
        sb_q.push_back(e);
    endtask

    // WB fires on a negedge following an edge where WB was not stalled.
    always @(posedge clk) cap = !wb_stall && rst_n;

    always @(negedge clk) begin
        if (cap && o_wb_v) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_npc",   o_wb_npc,        mon_e.npc);
                check("sb_alu",   o_wb_alu_result, mon_e.alu);
                check("sb_mem",   o_wb_mem_result, mon_e.mem);
                check("sb_fault", 64'(o_wb_fault), 64'(mon_e.fault));
                check("sb_csrfd", o_wb_csrfd,      mon_e.npc ^ 64'hFF);
                check("sb_drid",  64'(o_wb_drid),  64'(mon_e.npc[6:2]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1'b0, F3_H,  64'h2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        vec[1]  = '{1'b0, F3_HU, 64'h2, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001, 1'b0};
        vec[2]  = '{1'b0, F3_W,  64'h4, 64'h9ABC_DEF0_1234_5678, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
        vec[3]  = '{1'b0, F3_WU, 64'h4, 64'h9ABC_DEF0_1234_5678, 64'h0000_0000_9ABC_DEF0, 1'b0};
        vec[4]  = '{1'b0, F3_D,  64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
        vec[5]  = '{1'b0, F3_BU, 64'h7, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 1'b0};
        vec[6]  = '{1'b0, F3_B,  64'h1, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F, 1'b0};
        vec[7]  = '{1'b0, F3_W,  64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
        vec[8]  = '{1'b0, F3_D,  64'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
        vec[9]  = '{1'b1, F3_W,  64'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
        vec[10] = '{1'b0, F3_W,  64'hC, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF, 1'b0};

        rst_n = 1'b0; wb_stall = 1'b0; dm_rdata = '0;
        mem_funct3 = '0; mem_npc = '0; mem_alu = '0; mem_sr2 = '0; mem_csrfd = '0;
        mem_drid = '0; mem_ecall = 1'b0;
        idle_op();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_v",   64'(o_wb_v), 64'd0);
        check("rst_dm_req", 64'(o_dm_req), 64'd0);
        check("rst_state",  64'(dut.r_state), 64'(ST_IDLE));
        tick();
        rst_n = 1'b1;

        // Non-memory op passes straight through.
        tick();
        drive_op(1'b0, 1'b0, F3_D, 64'h1234, 64'h0, 64'h100);
        push(64'h100, 64'h1234, 64'h0, 1'b0);
        @(negedge clk);
        check("nm_stall",  64'(o_mem_stall), 64'd0);
        check("nm_dm_req", 64'(o_dm_req), 64'd0);
        tick();
        idle_op();
        @(negedge clk);
        check("nm_wb_v",   64'(o_wb_v), 64'd1);
        check("nm_wb_alu", o_wb_alu_result, 64'h1234);

        // LB with slow ready: 2 un-ready cycles, accept, one WAIT cycle, then rvalid.
        tick();
        drive_op(1'b1, 1'b0, F3_B, 64'h1003, 64'h0, 64'h200);
        dm_rdata = 64'h0000_0000_8000_0000;
        push(64'h200, 64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        nstall = 0;
        for (int c = 0; c < 5; c++) begin
            dm_ready  = (c == 2);
            dm_rvalid = (c == 4);
            @(negedge clk);
            if (o_mem_stall) nstall++;
            if (c < 3) check("lb_dm_req", 64'(o_dm_req), 64'd1);
            if (c == 1) check("lb_dm_addr", o_dm_addr, 64'h1003);
            tick();
        end
        idle_op();
        check("lb_stall_cycles", 64'(nstall), 64'd4);

        // SH at offset 6 with immediate ready.
        tick();
        drive_op(1'b0, 1'b1, F3_H, 64'h6, 64'h1234_0000_0000_BEEF, 64'h300);
        dm_ready = 1'b1;
        push(64'h300, 64'h6, 64'h0, 1'b0);
        @(negedge clk);
        check("sh_dm_req", 64'(o_dm_req), 64'd1);
        check("sh_dm_we",  64'(o_dm_we), 64'd1);
        check("sh_dm_be",  64'(o_dm_be), 64'hC0);
        check("sh_wdata",  o_dm_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        check("sh_stall",  64'(o_mem_stall), 64'd0);
        tick();
        idle_op();
        @(negedge clk);
        check("sh_wb_v", 64'(o_wb_v), 64'd1);

        // Table of loads and faulting accesses.
        for (int i = 0; i < 11; i++) begin
            tick();
            drive_op(!vec[i].st, vec[i].st, vec[i].f3, vec[i].addr, 64'hCAFE, 64'h400 + 64'(i * 4));
            dm_rdata = vec[i].rdata;
            dm_ready = 1'b1;
            push(64'h400 + 64'(i * 4), vec[i].addr, vec[i].exp, vec[i].flt);
            @(negedge clk);
            if (vec[i].flt) begin
                check($sformatf("v%0d_noreq", i), 64'(o_dm_req), 64'd0);
                check($sformatf("v%0d_stall", i), 64'(o_mem_stall), 64'd0);
                tick();
                idle_op();
                @(negedge clk);
                check($sformatf("v%0d_wb_fault", i), 64'(o_wb_fault), 64'd1);
                check($sformatf("v%0d_wb_v", i), 64'(o_wb_v), 64'd1);
            end else begin
                check($sformatf("v%0d_req", i), 64'(o_dm_req), 64'd1);
                check($sformatf("v%0d_stall_acc", i), 64'(o_mem_stall), 64'd1);
                tick();
                dm_ready = 1'b0;
                dm_rvalid = 1'b1;
                @(negedge clk);
                check($sformatf("v%0d_stall_rv", i), 64'(o_mem_stall), 64'd0);
                tick();
                idle_op();
            end
        end

        // Load whose data returns while WB is stalled: parks in HOLD.
        tick();
        drive_op(1'b0, 1'b0, F3_D, 64'h5555, 64'h0, 64'h500);
        push(64'h500, 64'h5555, 64'h0, 1'b0);
        tick();
        drive_op(1'b1, 1'b0, F3_W, 64'h10, 64'h0, 64'h600);
        dm_rdata = 64'h0000_0000_8899_AABB;
        dm_ready = 1'b1;
        wb_stall = 1'b1;
        push(64'h600, 64'h10, 64'hFFFF_FFFF_8899_AABB, 1'b0);
        tick();
        dm_ready = 1'b0;
        dm_rvalid = 1'b1;
        @(negedge clk);
        check("hold_stall_rv", 64'(o_mem_stall), 64'd1);
        tick();
        dm_rvalid = 1'b0;
        dm_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("hold_state",  64'(dut.r_state), 64'(ST_HOLD));
        check("hold_wb_alu", o_wb_alu_result, 64'h5555);
        check("hold_wb_v",   64'(o_wb_v), 64'd1);
        tick();
        @(negedge clk);
        check("hold_wb_npc", o_wb_npc, 64'h500);
        tick();
        wb_stall = 1'b0;
        @(negedge clk);
        check("hold_release_stall", 64'(o_mem_stall), 64'd0);
        tick();
        idle_op();
        @(negedge clk);
        check("hold_wb_mem", o_wb_mem_result, 64'hFFFF_FFFF_8899_AABB);
        check("hold_state_idle", 64'(dut.r_state), 64'(ST_IDLE));

        // Flush while waiting for data: response discarded.
        tick();
        drive_op(1'b1, 1'b0, F3_D, 64'h20, 64'h0, 64'h700);
        dm_ready = 1'b1;
        tick();
        dm_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flw_stall", 64'(o_mem_stall), 64'd1);
        tick();
        idle_op();
        tick();
        dm_rvalid = 1'b1;
        dm_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        check("flw_rv_stall", 64'(o_mem_stall), 64'd0);
        tick();
        idle_op();
        @(negedge clk);
        check("flw_state", 64'(dut.r_state), 64'(ST_IDLE));
        check("flw_wb_v",  64'(o_wb_v), 64'd0);

        // Flush of an un-accepted request in REQ.
        tick();
        drive_op(1'b1, 1'b0, F3_W, 64'h30, 64'h0, 64'h800);
        @(negedge clk);
        check("flr_req_before", 64'(o_dm_req), 64'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flr_req_withdrawn", 64'(o_dm_req), 64'd0);
        tick();
        idle_op();
        @(negedge clk);
        check("flr_state", 64'(dut.r_state), 64'(ST_IDLE));
        check("flr_wb_v",  64'(o_wb_v), 64'd0);

        // Asynchronous reset while a load is in WAIT and WB is frozen.
        tick();
        drive_op(1'b0, 1'b0, F3_D, 64'h9999, 64'h0, 64'h900);
        push(64'h900, 64'h9999, 64'h0, 1'b0);
        tick();
        drive_op(1'b1, 1'b0, F3_D, 64'h40, 64'h0, 64'hA00);
        dm_ready = 1'b1;
        wb_stall = 1'b1;
        tick();
        dm_ready = 1'b0;
        @(negedge clk);
        check("rw_state_wait", 64'(dut.r_state), 64'(ST_WAIT));
        check("rw_wb_v_held",  64'(o_wb_v), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_wb_v",     64'(o_wb_v), 64'd0);
        check("rw_wb_alu",   o_wb_alu_result, 64'h0);
        check("rw_wb_npc",   o_wb_npc, 64'h0);
        check("rw_dm_req",   64'(o_dm_req), 64'd0);
        check("rw_mem_stall", 64'(o_mem_stall), 64'd0);
        check("rw_state",    64'(dut.r_state), 64'(ST_IDLE));
        idle_op();
        wb_stall = 1'b0;
        tick();
        rst_n = 1'b1;

        // Stray read response with nothing outstanding.
        tick();
        dm_rvalid = 1'b1;
        dm_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        @(negedge clk);
        check("stray_stall", 64'(o_mem_stall), 64'd0);
        tick();
        dm_rvalid = 1'b0;
        @(negedge clk);
        check("stray_state", 64'(dut.r_state), 64'(ST_IDLE));
        check("stray_wb_v",  64'(o_wb_v), 64'd0);

        tick();
        tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
